async_fifo: RTL and testbench



---
 rtl/async_fifo.sv | 120 ++++++++++++
 tb/tb_async_fifo.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/async_fifo.sv
// -----------------------------------------------------------------------------
// async_fifo
//   Self-stimulating single-clock FIFO demonstrator. An internal generator
//   writes an incrementing DATA_W-bit sequence into a 2**ADDR_W-entry buffer
//   on every cycle that the buffer is not full. An internal rate divider issues
//   a read strobe every RD_DIV cycles, and each strobe drains one entry while
//   the buffer is not empty. The block models a fast producer that feeds a slow
//   consumer.
//
//   Optional feature: defining ASYNC_FIFO_LEVEL_EN adds the `level` output,
//   which is the current occupancy (wptr - rptr).
//
// Ports
//   clk       in   1         single clock, rising edge
//   reset     in   1         asynchronous, active-high; clears all state
//   data_out  out  DATA_W    last word read (registered)
//   wr_full   out  1         buffer holds 2**ADDR_W entries
//   rd_empty  out  1         buffer holds 0 entries
//   level     out  ADDR_W+1  occupancy 0..2**ADDR_W (ASYNC_FIFO_LEVEL_EN only)
// -----------------------------------------------------------------------------
module async_fifo #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4,
  parameter int RD_DIV = 10
) (
  input  logic              clk,
  input  logic              reset,
  output logic [DATA_W-1:0] data_out,
  output logic              wr_full,
  output logic              rd_empty
`ifdef ASYNC_FIFO_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int DIV_W = $clog2(RD_DIV);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [ADDR_W:0]   rptr_q, rptr_d;
  logic [DATA_W-1:0] gen_q, gen_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic strobe;
  logic wr_en;
  logic rd_en;

  // The extra pointer MSB tells apart full (laps differ) and empty (same lap)
  // when the address bits are equal.
  assign rd_empty = (wptr_q == rptr_q);
  assign wr_full  = (wptr_q[ADDR_W] != rptr_q[ADDR_W]) &&
                    (wptr_q[ADDR_W-1:0] == rptr_q[ADDR_W-1:0]);

  // The divider free-runs and does not depend on the FIFO state.
  assign strobe = (div_q == DIV_W'(RD_DIV - 1));

  // The flags come from the registered pointers, so a read and a write in the
  // same edge cannot unblock each other.
  assign wr_en = !wr_full;
  assign rd_en = strobe && !rd_empty;

  always_comb begin
    // NOTE: every combinational output gets a default first, so that no path
    // leaves a variable unassigned and no latch is inferred.
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    gen_d  = gen_q;
    data_d = data_q;
    div_d  = strobe ? '0 : div_q + DIV_W'(1);

    if (wr_en) begin
      wptr_d = wptr_q + (ADDR_W+1)'(1);
      gen_d  = gen_q + DATA_W'(1);
    end

    if (rd_en) begin
      rptr_d = rptr_q + (ADDR_W+1)'(1);
      data_d = mem_q[rptr_q[ADDR_W-1:0]];
    end
  end

  // NOTE: state registers use non-blocking assignments so that every register
  // samples the pre-edge values, whatever order the blocks are evaluated in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      gen_q  <= '0;
      div_q  <= '0;
      data_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      gen_q  <= gen_d;
      div_q  <= div_d;
      data_q <= data_d;
    end
  end

  // NOTE: the storage array has no reset. An entry is read only after it has
  // been written, so its power-up value is never observed, and leaving out the
  // reset lets the array map onto plain storage.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wptr_q[ADDR_W-1:0]] <= gen_q;
    end
  end

  assign data_out = data_q;

`ifdef ASYNC_FIFO_LEVEL_EN
  // The subtraction modulo 2**(ADDR_W+1) gives 0..DEPTH without any special case.
  assign level = wptr_q - rptr_q;
`endif

endmodule

// File: tb/tb_async_fifo.sv
// -----------------------------------------------------------------------------
// tb_async_fifo
//   Directed bench for async_fifo using the default parameters. Rising clock
//   edges occur at 10 ns, 20 ns, ... and outputs are sampled on the falling
//   edge that follows each rising edge. Expected values are hand-computed from
//   the producer/consumer timing. Checks of `level` are compiled in only when
//   ASYNC_FIFO_LEVEL_EN is defined.
// -----------------------------------------------------------------------------
module tb_async_fifo;

  logic       clk;
  logic       reset;
  logic [7:0] data_out;
  logic       wr_full;
  logic       rd_empty;
`ifdef ASYNC_FIFO_LEVEL_EN
  logic [4:0] level;
`endif

  async_fifo #(
    .DATA_W(8),
    .ADDR_W(4),
    .RD_DIV(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .data_out (data_out),
    .wr_full  (wr_full),
    .rd_empty (rd_empty)
`ifdef ASYNC_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  // clk starts high, falls at 5 ns and rises at 10 ns, 20 ns, ...
  initial begin
    clk = 1'b1;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;

  typedef struct {
    int         edge_k;
    logic [7:0] data;
    logic       empty;
    logic       full;
    logic [4:0] lvl;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d, t=%0t)", name, act, exp, edge_cnt, $time);
    end
  endtask

  // Advances to just after rising edge k, then waits for the falling edge that follows.
  task automatic step_to(input int k);
    while (edge_cnt < k) begin
      @(posedge clk);
      edge_cnt++;
    end
    @(negedge clk);
  endtask

  task automatic check_state(input string tag, input logic [7:0] d, input logic e,
                             input logic f, input logic [4:0] l);
    check({tag, ".data_out"}, 32'(data_out), 32'(d));
    check({tag, ".rd_empty"}, 32'(rd_empty), 32'(e));
    check({tag, ".wr_full"},  32'(wr_full),  32'(f));
`ifdef ASYNC_FIFO_LEVEL_EN
    check({tag, ".level"}, 32'(level), 32'(l));
`else
    if (l > 5'd16) $display("note: level vector out of range");
`endif
  endtask

  // Watchdog: the run below needs roughly 27 us.
  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Fields: edge, data_out, rd_empty, wr_full, level
    vecs.push_back('{1,  8'd0, 1'b0, 1'b0, 5'd1});
    vecs.push_back('{9,  8'd0, 1'b0, 1'b0, 5'd9});
    vecs.push_back('{10, 8'd0, 1'b0, 1'b0, 5'd9});
    vecs.push_back('{16, 8'd0, 1'b0, 1'b0, 5'd15});
    vecs.push_back('{17, 8'd0, 1'b0, 1'b1, 5'd16});
    vecs.push_back('{18, 8'd0, 1'b0, 1'b1, 5'd16});
    vecs.push_back('{19, 8'd0, 1'b0, 1'b1, 5'd16});
    vecs.push_back('{20, 8'd1, 1'b0, 1'b0, 5'd15});
    vecs.push_back('{21, 8'd1, 1'b0, 1'b1, 5'd16});
    vecs.push_back('{29, 8'd1, 1'b0, 1'b1, 5'd16});
    vecs.push_back('{30, 8'd2, 1'b0, 1'b0, 5'd15});
    vecs.push_back('{31, 8'd2, 1'b0, 1'b1, 5'd16});
    vecs.push_back('{33, 8'd2, 1'b0, 1'b1, 5'd16});

    // Reset state, checked before any rising edge after release.
    reset = 1'b1;
    #3;
    check_state("reset_hold", 8'd0, 1'b1, 1'b0, 5'd0);
    #2 reset = 1'b0;  // release at 5 ns, on a falling edge
    #1;
    check_state("reset_rel", 8'd0, 1'b1, 1'b0, 5'd0);

    // Table-driven phase: fill, saturate and enter steady state.
    for (int i = 0; i < vecs.size(); i++) begin
      step_to(vecs[i].edge_k);
      check_state($sformatf("vec%0d_e%0d", i, vecs[i].edge_k),
                  vecs[i].data, vecs[i].empty, vecs[i].full, vecs[i].lvl);
    end

    // Reset between edges 33 and 34 must clear the outputs without a clock edge.
    reset = 1'b1;
    #1;
    check_state("midreset", 8'd0, 1'b1, 1'b0, 5'd0);
    #2 reset = 1'b0;  // released 2 ns before the next rising edge
    edge_cnt = 0;
    #1;
    check_state("midreset_rel", 8'd0, 1'b1, 1'b0, 5'd0);

    step_to(1);
    check("restart_e1.rd_empty", 32'(rd_empty), 32'd0);

    // Long run: data_out = n mod 256 right after edge 10*(n+1), and it holds its
    // previous value on the edge just before. The run spans the 255->0 wrap of
    // the generator.
    for (int n = 0; n <= 260; n++) begin
      step_to(10 * (n + 1) - 1);
      check($sformatf("pre_read%0d", n), 32'(data_out),
            (n == 0) ? 32'd0 : 32'((n - 1) % 256));
      step_to(10 * (n + 1));
      check($sformatf("read%0d", n), 32'(data_out), 32'(n % 256));
      if (n >= 2) begin
        check($sformatf("read%0d.wr_full", n), 32'(wr_full), 32'd0);
      end
    end
    step_to(2612);
    check("wrap_refill.wr_full", 32'(wr_full), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
